// File: rtl/race_game_ctrl.sv
// Frame-synchronous game sequencer for the racing display.
// Owns the car and obstacle positions, advances them once per frame,
// respawns obstacles into LFSR-chosen lanes, detects collisions, and
// keeps score and speed. All outputs come straight from registers.
module race_game_ctrl #(
  parameter int CAR_STEP     = 4,
  parameter int CAR_V        = 400,
  parameter int SPEED_INIT   = 2,
  parameter int SPEED_MAX    = 8,
  parameter int CRASH_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] lfsr,
  output logic [9:0] carro_h_pos,
  output logic [8:0] carro_v_pos,
  output logic [9:0] obs1_h_pos,
  output logic [9:0] obs2_h_pos,
  output logic [8:0] obs1_v_pos,
  output logic [8:0] obs2_v_pos,
  output logic [7:0] score,
  output logic       game_over
);

  localparam logic [9:0]  LANE0      = 10'd159;
  localparam logic [9:0]  LANE1      = 10'd295;
  localparam logic [9:0]  LANE2      = 10'd431;
  localparam logic [9:0]  CAR_MIN    = 10'd120;
  localparam logic [9:0]  CAR_MAX    = 10'd470;
  localparam logic [9:0]  CAR_HOME   = 10'd295;
  localparam logic [9:0]  OBS_BOTTOM = 10'd480;
  localparam logic [8:0]  OBS2_HOME  = 9'd240;
  localparam logic [9:0]  STEP       = 10'(CAR_STEP);
  localparam logic [8:0]  CAR_TOP    = 9'(CAR_V);
  localparam logic [3:0]  SPD_INIT   = 4'(SPEED_INIT);
  localparam logic [5:0]  SPD_MAX6   = 6'(SPEED_MAX);
  localparam logic [6:0]  CRASH_LAST = 7'(CRASH_FRAMES - 1);
  localparam logic [10:0] SIZE       = 11'd50;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CRASH = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  car_h_reg, car_h_next;
  logic [9:0]  obs_h_reg [2];
  logic [9:0]  obs_h_next [2];
  logic [8:0]  obs_v_reg [2];
  logic [8:0]  obs_v_next [2];
  logic [7:0]  score_reg, score_next;
  logic [3:0]  speed_reg, speed_next;
  logic [6:0]  crash_cnt_reg, crash_cnt_next;
  logic        game_over_reg, game_over_next;

  logic [9:0]  obs_sum [2];
  logic [1:0]  respawn;
  logic [1:0]  hit_obs;
  logic [1:0]  lane_raw [2];
  logic [1:0]  lane_sel [2];
  logic        hit;
  logic        crash_done;
  logic [8:0]  score_sum;
  logic [7:0]  score_new;
  logic [5:0]  speed_calc;
  logic [3:0]  speed_new;
  logic [9:0]  car_left, car_right;
  logic        unused_lfsr;

  // Codes 0..2 map straight to lanes; code 3 doubles up on the middle lane.
  function automatic logic [1:0] lane_idx(input logic [1:0] code);
    return (code == 2'd3) ? 2'd1 : code;
  endfunction

  function automatic logic [9:0] lane_col(input logic [1:0] idx);
    case (idx)
      2'd0:    return LANE0;
      2'd1:    return LANE1;
      default: return LANE2;
    endcase
  endfunction

  // 50x50 box overlap, widened to 11 bits so the +50 edges never wrap.
  function automatic logic overlap(input logic [9:0] o_h, input logic [8:0] o_v,
                                   input logic [9:0] c_h);
    logic [10:0] oh, ov, ch, cv;
    oh = {1'b0, o_h};
    ov = {2'b0, o_v};
    ch = {1'b0, c_h};
    cv = {2'b0, CAR_TOP};
    return (oh < ch + SIZE) && (ch < oh + SIZE) && (ov < cv + SIZE) && (cv < ov + SIZE);
  endfunction

  // Per-obstacle fall, respawn and collision terms.
  for (genvar gi = 0; gi < 2; gi++) begin : g_obs
    assign obs_sum[gi]  = {1'b0, obs_v_reg[gi]} + {6'd0, speed_reg};
    assign respawn[gi]  = (obs_sum[gi] >= OBS_BOTTOM);
    assign hit_obs[gi]  = overlap(obs_h_reg[gi], obs_v_reg[gi], car_h_reg);
    assign lane_raw[gi] = lane_idx(lfsr[2*gi+1 -: 2]);
  end

  // Two simultaneous respawns never share a lane: obs2 moves one lane over.
  assign lane_sel[0] = lane_raw[0];
  assign lane_sel[1] = (respawn[0] && respawn[1] && (lane_raw[0] == lane_raw[1]))
                     ? ((lane_raw[1] == 2'd2) ? 2'd0 : lane_raw[1] + 2'd1)
                     : lane_raw[1];

  assign hit         = |hit_obs;
  assign crash_done  = frame_tick && (crash_cnt_reg == CRASH_LAST);
  assign score_sum   = {1'b0, score_reg} + {8'd0, respawn[0]} + {8'd0, respawn[1]};
  assign score_new   = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign speed_calc  = {2'b0, SPD_INIT} + {1'b0, score_new[7:3]};
  assign speed_new   = (speed_calc > SPD_MAX6) ? SPD_MAX6[3:0] : speed_calc[3:0];
  assign car_left    = (car_h_reg >= CAR_MIN + STEP) ? car_h_reg - STEP : CAR_MIN;
  assign car_right   = (car_h_reg + STEP <= CAR_MAX) ? car_h_reg + STEP : CAR_MAX;
  assign unused_lfsr = ^lfsr[9:4];

  // State and datapath registers; reset restores the idle screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      car_h_reg     <= CAR_HOME;
      obs_h_reg[0]  <= LANE0;
      obs_v_reg[0]  <= 9'd0;
      obs_h_reg[1]  <= LANE2;
      obs_v_reg[1]  <= OBS2_HOME;
      score_reg     <= 8'd0;
      speed_reg     <= SPD_INIT;
      crash_cnt_reg <= 7'd0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      car_h_reg     <= car_h_next;
      obs_h_reg     <= obs_h_next;
      obs_v_reg     <= obs_v_next;
      score_reg     <= score_next;
      speed_reg     <= speed_next;
      crash_cnt_reg <= crash_cnt_next;
      game_over_reg <= game_over_next;
    end
  end

  // Next-state: start launches a game, a hit ends it, the crash timer returns to idle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (hit) state_next = CRASH;
      CRASH:   if (crash_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: idle pins home positions, run advances on frame ticks.
  always_comb begin
    car_h_next     = car_h_reg;
    obs_h_next     = obs_h_reg;
    obs_v_next     = obs_v_reg;
    score_next     = score_reg;
    speed_next     = speed_reg;
    crash_cnt_next = crash_cnt_reg;
    if (state_reg == IDLE || (state_reg == CRASH && crash_done)) begin
      car_h_next     = CAR_HOME;
      obs_h_next[0]  = LANE0;
      obs_v_next[0]  = 9'd0;
      obs_h_next[1]  = LANE2;
      obs_v_next[1]  = OBS2_HOME;
      score_next     = 8'd0;
      speed_next     = SPD_INIT;
      crash_cnt_next = 7'd0;
    end else if (state_reg == RUN && frame_tick) begin
      if (btn_left && !btn_right) begin
        car_h_next = car_left;
      end else if (btn_right && !btn_left) begin
        car_h_next = car_right;
      end
      for (int i = 0; i < 2; i++) begin
        if (respawn[i]) begin
          obs_v_next[i] = 9'd0;
          obs_h_next[i] = lane_col(lane_sel[i]);
        end else begin
          obs_v_next[i] = obs_sum[i][8:0];
        end
      end
      score_next = score_new;
      speed_next = speed_new;
    end else if (state_reg == CRASH && frame_tick) begin
      crash_cnt_next = crash_cnt_reg + 7'd1;
    end
    game_over_next = (state_next == CRASH);
  end

  assign carro_h_pos = car_h_reg;
  assign carro_v_pos = CAR_TOP;
  assign obs1_h_pos  = obs_h_reg[0];
  assign obs1_v_pos  = obs_v_reg[0];
  assign obs2_h_pos  = obs_h_reg[1];
  assign obs2_v_pos  = obs_v_reg[1];
  assign score       = score_reg;
  assign game_over   = game_over_reg;

endmodule

// File: tb/tb_race_game_ctrl.sv
// Bench for race_game_ctrl: a frame-level game model checked against the
// DUT on every falling edge, plus hand-computed checkpoints per scenario.
module tb_race_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, frame_tick, start, btn_left, btn_right;
  logic [9:0] lfsr;
  logic [9:0] carro_h_pos, obs1_h_pos, obs2_h_pos;
  logic [8:0] carro_v_pos, obs1_v_pos, obs2_v_pos;
  logic [7:0] score;
  logic       game_over;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model of the game: 0 idle, 1 running, 2 crashed.
  int m_st = 0;
  int m_car, m_o1h, m_o1v, m_o2h, m_o2v, m_score, m_speed, m_go, m_cnt;
  int m_resp = 0;
  int lane_of_code [4] = '{0, 1, 2, 1};

  always #5 clk = ~clk;

  race_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .lfsr       (lfsr),
    .carro_h_pos(carro_h_pos),
    .carro_v_pos(carro_v_pos),
    .obs1_h_pos (obs1_h_pos),
    .obs2_h_pos (obs2_h_pos),
    .obs1_v_pos (obs1_v_pos),
    .obs2_v_pos (obs2_v_pos),
    .score      (score),
    .game_over  (game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Two 50-wide spans starting at a and b intersect.
  function automatic bit spans_meet(input int a, input int b);
    int lo, hi;
    lo = (a < b) ? a : b;
    hi = (a > b) ? a : b;
    return hi < lo + 50;
  endfunction

  task automatic m_home();
    m_car = 295; m_o1h = 159; m_o1v = 0; m_o2h = 431; m_o2v = 240;
    m_score = 0; m_speed = 2; m_go = 0; m_cnt = 0;
  endtask

  // Game model, advanced on every rising edge from the same inputs as the DUT.
  always @(posedge clk) begin : model
    bit hit, r1, r2;
    int l1, l2, total;
    if (reset) begin
      m_home();
      m_st = 0;
    end else begin
      case (m_st)
        0: begin
          m_home();
          if (start) m_st = 1;
        end
        1: begin
          hit = (spans_meet(m_o1h, m_car) && spans_meet(m_o1v, 400)) ||
                (spans_meet(m_o2h, m_car) && spans_meet(m_o2v, 400));
          if (frame_tick) begin
            if (btn_left && !btn_right) m_car = (m_car - 4 < 120) ? 120 : m_car - 4;
            if (btn_right && !btn_left) m_car = (m_car + 4 > 470) ? 470 : m_car + 4;
            r1 = (m_o1v + m_speed >= 480);
            r2 = (m_o2v + m_speed >= 480);
            l1 = lane_of_code[lfsr % 4];
            l2 = lane_of_code[(lfsr / 4) % 4];
            if (r1 && r2 && l1 == l2) l2 = (l2 + 1) % 3;
            if (r1) begin m_o1v = 0; m_o1h = 159 + 136 * l1; end
            else m_o1v = m_o1v + m_speed;
            if (r2) begin m_o2v = 0; m_o2h = 159 + 136 * l2; end
            else m_o2v = m_o2v + m_speed;
            total = m_score + int'(r1) + int'(r2);
            m_score = (total > 255) ? 255 : total;
            m_speed = (2 + m_score / 8 > 8) ? 8 : 2 + m_score / 8;
            m_resp = m_resp + int'(r1) + int'(r2);
          end
          if (hit) begin m_st = 2; m_go = 1; end
        end
        2: begin
          if (frame_tick) begin
            m_cnt++;
            if (m_cnt == 120) begin m_home(); m_st = 0; end
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("car_h", carro_h_pos, m_car);
      chk("car_v", carro_v_pos, 400);
      chk("obs1_h", obs1_h_pos, m_o1h);
      chk("obs1_v", obs1_v_pos, m_o1v);
      chk("obs2_h", obs2_h_pos, m_o2h);
      chk("obs2_v", obs2_v_pos, m_o2v);
      chk("score", score, m_score);
      chk("game_over", game_over, m_go);
    end
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_home(input string tag);
    chk({tag, "_car_h"}, carro_h_pos, 295);
    chk({tag, "_obs1_h"}, obs1_h_pos, 159);
    chk({tag, "_obs1_v"}, obs1_v_pos, 0);
    chk({tag, "_obs2_h"}, obs2_h_pos, 431);
    chk({tag, "_obs2_v"}, obs2_v_pos, 240);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_game_over"}, game_over, 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int guard, base;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; lfsr = 10'd2;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    reset = 1'b0;
    chk_home("reset");

    // Idle ignores ticks, including one coinciding with start.
    ticks(3);
    chk("idle_tick_obs1_v", obs1_v_pos, 0);
    start = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    start = 1'b0; frame_tick = 1'b0;
    chk("start_tick_obs2_v", obs2_v_pos, 240);
    ticks(10);
    chk("run10_obs1_v", obs1_v_pos, 20);
    chk("run10_obs2_v", obs2_v_pos, 260);
    chk("run10_car_h", carro_h_pos, 295);
    chk("run10_score", score, 0);
    $display("scenario start: obs1_v=%0d obs2_v=%0d", obs1_v_pos, obs2_v_pos);

    // Left clamp, both buttons, then a short right move.
    btn_left = 1'b1;
    ticks(50);
    chk("left_clamp", carro_h_pos, 120);
    btn_right = 1'b1;
    ticks(5);
    chk("both_buttons", carro_h_pos, 120);
    btn_left = 1'b0;
    ticks(3);
    chk("right_3", carro_h_pos, 132);
    btn_right = 1'b0;
    $display("scenario buttons: car_h=%0d", carro_h_pos);

    // Reset wins over a coincident frame tick.
    reset = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    reset = 1'b0; frame_tick = 1'b0;
    chk_home("midreset");

    // Right clamp.
    press_start();
    btn_right = 1'b1;
    ticks(50);
    btn_right = 1'b0;
    chk("right_clamp", carro_h_pos, 470);
    chk("right_obs2_v", obs2_v_pos, 340);
    $display("scenario right clamp: car_h=%0d", carro_h_pos);
    do_reset();

    // Respawn lanes, then a collision and the crash timeout.
    lfsr = 10'd2;
    press_start();
    ticks(239);
    chk("pre_respawn_obs1_v", obs1_v_pos, 478);
    tick();
    chk("respawn_obs1_v", obs1_v_pos, 0);
    chk("respawn_obs1_h", obs1_h_pos, 431);
    chk("respawn_score", score, 2);
    ticks(239);
    lfsr = 10'd3;
    tick();
    lfsr = 10'd2;
    chk("code3_obs1_h", obs1_h_pos, 295);
    chk("code3_score", score, 4);
    $display("scenario respawn: obs1_h=%0d score=%0d", obs1_h_pos, score);
    ticks(175);
    chk("near_hit_obs1_v", obs1_v_pos, 350);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("hit_obs1_v", obs1_v_pos, 352);
    chk("hit_go_plus1", game_over, 0);
    @(negedge clk);
    chk("hit_go_plus2", game_over, 1);
    chk("crash_score", score, 5);
    start = 1'b1;
    ticks(119);
    start = 1'b0;
    chk("crash119_go", game_over, 1);
    chk("crash119_obs1_v", obs1_v_pos, 352);
    tick();
    chk_home("crash_end");
    $display("scenario crash: game_over=%0d score=%0d", game_over, score);
    do_reset();

    // Speed step at score 8, then saturation at 255.
    lfsr = 10'd8;
    press_start();
    ticks(840);
    chk("score7", score, 7);
    ticks(120);
    chk("score8", score, 8);
    chk("score8_obs1_v", obs1_v_pos, 0);
    chk("score8_obs2_v", obs2_v_pos, 240);
    tick();
    chk("speed3_obs1_v", obs1_v_pos, 3);
    chk("speed3_obs2_v", obs2_v_pos, 243);
    $display("scenario speed: score=%0d obs1_v=%0d", score, obs1_v_pos);
    guard = 0;
    while (m_score < 255 && guard < 15000) begin
      tick();
      guard++;
    end
    chk("score_reaches_255", score, 255);
    base = m_resp;
    guard = 0;
    while (m_resp < base + 4 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("score_saturated", score, 255);
    chk("respawns_after_255", m_resp - base >= 4, 1);
    $display("scenario saturate: score=%0d", score);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_game_ctrl.md
Name: race_game_ctrl

Overview:
- Frame-synchronous game sequencer for the racing display.
- Owns every position register consumed by the pixel drawer: player car, and obstacles 1/2 (vertical and horizontal).
- Advances game state once per video frame, applies player input, respawns obstacles into lanes chosen by the LFSR, detects collisions, and keeps score and speed.

Parameters:
- CAR_STEP, 4: horizontal pixels the car moves per frame while a button is held.
- CAR_V, 400: fixed car top row.
- SPEED_INIT, 2: obstacle pixels per frame after start.
- SPEED_MAX, 8: speed ceiling.
- CRASH_FRAMES, 120: frames spent in CRASH before returning to IDLE.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blanking)
- start  in  1  level; begins a game from IDLE
- btn_left  in  1  level, move car left
- btn_right  in  1  level, move car right
- lfsr  in  10  free-running pseudo-random value
- carro_h_pos  out  10  car left column
- carro_v_pos  out  9  car top row (constant CAR_V)
- obs1_h_pos, obs2_h_pos  out  10 each  obstacle left columns
- obs1_v_pos, obs2_v_pos  out  9 each  obstacle top rows
- score  out  8  obstacles passed, saturating at 255
- game_over  out  1  high while in CRASH

Behaviour:
- Geometry: all sprites are 50x50. Lane left columns: L0=159, L1=295, L2=431. Car column clamp: [120, 470].
- Reset values: state IDLE; carro_h_pos=295; carro_v_pos=CAR_V; obs1 at (159, 0); obs2 at (431, 240); score=0; speed=SPEED_INIT; game_over=0; crash frame counter=0.
- All outputs are registered.
- FSM: IDLE -> RUN -> CRASH -> IDLE.
- IDLE:
  - Outputs held at reset values.
  - start=1 -> RUN at the next edge.
  - frame_tick is ignored in IDLE, including when it coincides with start.
- RUN: updates occur only on the edge where frame_tick=1; new values are visible the following cycle.
  - Car: btn_left only -> h = max(h-CAR_STEP, 120). btn_right only -> h = min(h+CAR_STEP, 470). Both or neither -> no change.
  - Obstacle n: compute next = v + speed in 10-bit arithmetic (no 9-bit wrap).
    - next >= 480: v <= 0; h <= lane(sel); score += 1 (saturating).
    - Otherwise: v <= next[8:0].
  - Lane select: obs1 uses lfsr[1:0], obs2 uses lfsr[3:2]. Code 0 -> L0, 1 -> L1, 2 -> L2, 3 -> L1.
  - If obs1 and obs2 respawn on the same tick: score += 2 (saturating). If they would also land in the same lane, obs2 takes the next lane mod 3.
  - Speed: recomputed from the post-increment score as min(SPEED_INIT + score/8, SPEED_MAX). Takes effect on the next tick.
  - Collision:
    - Evaluated every cycle in RUN on the registered positions.
    - Car overlaps obs n when obs_h < car_h+50, car_h < obs_h+50, obs_v < CAR_V+50, and CAR_V < obs_v+50. Use 11-bit comparisons.
    - A hit moves the FSM to CRASH at the next edge, so game_over rises 2 cycles after the tick that caused the overlap.
- CRASH:
  - Positions and score are frozen; game_over=1.
  - The counter increments on each frame_tick. At CRASH_FRAMES the FSM moves to IDLE, all registers take their reset values, and game_over=0.
  - start is ignored while in CRASH.
- Reset mid-game: any state returns to IDLE with reset values on the next edge. Reset has priority over frame_tick and start.

Test Plan:
- Reset, then start=1 for 1 cycle, then 10 ticks with no buttons -> state RUN; obs1_v=20; obs2_v=260; carro_h_pos=295; score=0.
- RUN, btn_left held for 50 ticks from h=295 -> h steps by 4 and saturates at 120. Both buttons held -> h unchanged.
- obs1_v=478, speed=2, lfsr[1:0]=2, one tick -> obs1_v=0, obs1_h=431, score+1. With lfsr[1:0]=3 -> obs1_h=295.
- Force score to 7, then trigger a respawn -> score=8 and speed=3 from the following tick. Score at 255 plus a respawn -> stays 255.
- Car at 295, obs1_h=295, obs1_v reaching 352 on a tick -> game_over=1 exactly 2 cycles after the tick. After 120 ticks -> IDLE with reset values.
- Assert reset mid-RUN while frame_tick=1 -> next cycle shows IDLE reset values and no position update.
